// File: rtl/prog_seq_pkg.sv
// prog_seq_pkg: shared FSM states, program entry table and index type for prog_sequencer
package prog_seq_pkg;
  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, DONE} state_t;
  typedef logic [1:0] prog_idx_t;
  localparam int PROG1_PC = 0;
  localparam int PROG2_PC = 256;
  localparam int PROG3_PC = 512;
  function automatic int prog_pc(prog_idx_t idx);
    return idx == 2'd2 ? PROG3_PC : idx == 2'd1 ? PROG2_PC : PROG1_PC;
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: clearable up-counter that sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) q <= '0;
    else if (clr) q <= '0;
    else if (en && !(&q)) q <= q + 1'b1;
endmodule

// File: rtl/prog_sequencer.sv
// prog_sequencer: launches resident programs round-robin on req, watches halt/watchdog, raises ack
module prog_sequencer
  import prog_seq_pkg::*;
#(
  parameter int               PC_W       = 10,
  parameter int               CNT_W      = 16,
  parameter logic [CNT_W-1:0] MAX_CYCLES = CNT_W'(50000)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             halt,
  output logic             start,
  output logic [PC_W-1:0]  start_pc,
  output logic             run_en,
  output logic [1:0]       prog_sel,
  output logic             ack,
  output logic             timeout,
  output logic [CNT_W-1:0] cycles
);
  state_t state, nxt;
  logic   wd_hit;
  assign wd_hit   = (MAX_CYCLES != '0) && (cycles == MAX_CYCLES - 1'b1);
  assign start_pc = PC_W'(prog_pc(prog_sel));
  always_comb
    nxt = state == IDLE   ? (req ? LAUNCH : IDLE) :
          state == LAUNCH ? RUN :
          state == RUN    ? ((halt || wd_hit) ? DONE : RUN) :
                            (req ? LAUNCH : DONE);
  // outputs are registered from the next state so they line up with it exactly
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state    <= IDLE;
      start    <= 1'b0;
      run_en   <= 1'b0;
      ack      <= 1'b0;
      timeout  <= 1'b0;
      prog_sel <= 2'd0;
    end else begin
      state  <= nxt;
      start  <= nxt == LAUNCH;
      run_en <= nxt == RUN;
      ack    <= nxt == DONE;
      if (nxt == LAUNCH) timeout <= 1'b0;
      else if (state == RUN && !halt && wd_hit) timeout <= 1'b1;
      if (state == DONE && req) prog_sel <= prog_sel == 2'd2 ? 2'd0 : prog_sel + 2'd1;
    end
  sat_counter #(.W(CNT_W)) u_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (nxt == LAUNCH),
    .en   (state == RUN),
    .q    (cycles)
  );
endmodule
